tdm_demux_1x4: RTL and testbench
================================

Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the 4-to-1 selector: takes one time-division-multiplexed stream carrying four channels in fixed slot order (E0, E1, E2, E3) and distributes each slot back to its own registered output.
- Frame alignment comes from a sync pulse on slot 0. The four outputs update together once per complete frame, with a one-cycle valid strobe.
- Sits downstream of any 4-slot TDM source in the lab designs. Feeds per-channel consumers.

Parameters:
- W, 1, data width of the stream and of each channel output.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  slot strobe; din/sync are sampled only on cycles with en=1.
- sync  input  1  marks the slot-0 sample of a frame; qualified by en.
- din  input  W  multiplexed stream sample.
- D0, D1, D2, D3  output  W each  demultiplexed channel registers.
- slot  output  2  index of the next expected slot (S1,S0 equivalent).
- locked  output  1  1 while in RUN state.
- frame_valid  output  1  one-cycle pulse: D0..D3 just updated with a complete frame.
- sync_err  output  1  one-cycle pulse on an alignment fault.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: D0..D3=0, slot=0, locked=0, frame_valid=0, sync_err=0, state=IDLE, shadow registers=0.
- Internal state:
  - 2-bit slot counter cnt, driven directly to the slot output.
  - Shadow registers sh0..sh2 (W bits each).
  - FSM with two states, IDLE and RUN.
- en=0: all state held. frame_valid and sync_err drop to 0 (pulses only).
- IDLE, en=1, sync=0: sample discarded; stay IDLE.
- IDLE, en=1, sync=1: sh0<=din; cnt<=1; go RUN; locked=1 from next cycle.
- RUN, en=1, sync=0, cnt in {1,2}: sh[cnt]<=din; cnt<=cnt+1.
- RUN, en=1, sync=0, cnt=3 (frame complete):
  - D0<=sh0, D1<=sh1, D2<=sh2, D3<=din, all in the same edge.
  - cnt<=0 (wrap); frame_valid=1 on the following cycle.
  - Latency: last slot sampled at edge N; D0..D3 and frame_valid visible after edge N.
- RUN, en=1, sync=1, cnt=0: normal frame start; sh0<=din; cnt<=1.
- RUN, en=1, sync=1, cnt!=0 (early sync):
  - sync_err pulse; partial frame discarded; D0..D3 unchanged.
  - Resynchronise on this sample: sh0<=din, cnt<=1, stay RUN.
- RUN, en=1, sync=0, cnt=0 (missing sync):
  - sync_err pulse; go IDLE; cnt<=0; locked=0; D0..D3 unchanged.
- D0..D3 change only on a frame-complete edge and are never partially updated.
- Simultaneous events: sync_err and frame_valid are never both 1 in the same cycle.
- Reset mid-frame: immediate return to reset values, including D0..D3. The next frame requires a fresh sync.
- All widths are W. cnt wrap from 3 to 0 is natural 2-bit overflow.

Decomposition:
- Shared package/include: state encodings IDLE=1'b0, RUN=1'b1; constant NSLOTS=4.
- No sub-module is needed. The FSM, counter, shadow registers and output registers form a single module.

Test Plan:
- Reset/idle: rst_n low for 3 cycles with random din/sync -> all outputs 0, locked=0. Release with sync=0, en=1 for 5 samples -> still IDLE, no pulses.
- Basic frame, W=4:
  - Stimulus: en=1 continuous; sync on the first sample; din=A,B,C,D.
  - Response: one cycle after D is sampled, D0..D3=A,B,C,D and frame_valid=1 for exactly one cycle; slot sequence 1,2,3,0.
- Gapped en: same frame with en=0 for 2 cycles between each sample -> identical outputs; slot holds during gaps; a single frame_valid pulse.
- Back-to-back frames: 3, 5, 7, 9 then 1, 2, 4, 8 with sync on the first sample of each -> two frame_valid pulses exactly 4 en-cycles apart; final D0..D3=1,2,4,8.
- Early sync:
  - Stimulus: sync on sample 0, then sync again on sample 2 (cnt=2), followed by 4 good samples.
  - Response: sync_err pulse; D0..D3 retain the prior frame. The resync sample becomes D0 of the next frame, completed after 3 more samples.
- Missing sync and async reset:
  - After a full frame, a sample with sync=0 at cnt=0 -> sync_err=1, locked=0, then IDLE.
  - Separately, assert rst_n at cnt=2 between clock edges -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tdm_demux_1x4_pkg.sv
// Shared definitions for the 4-slot TDM receive demultiplexer.
package tdm_demux_1x4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned NSLOTS = 4;
  localparam int unsigned SLOT_W = $clog2(NSLOTS);

endpackage

// File: rtl/tdm_demux_1x4.sv
// Splits a sync-aligned 4-slot TDM stream back into four registered channels,
// publishing all four together once per complete frame.
module tdm_demux_1x4
  import tdm_demux_1x4_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic [W-1:0] din,
  output logic [W-1:0] D0,
  output logic [W-1:0] D1,
  output logic [W-1:0] D2,
  output logic [W-1:0] D3,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         frame_valid,
  output logic         sync_err
);

  state_e            state_r;
  logic [SLOT_W-1:0] cnt_r;
  logic [W-1:0]      sh0_r, sh1_r, sh2_r;
  logic [W-1:0]      d0_r, d1_r, d2_r, d3_r;
  logic              fv_r;
  logic              err_r;

  // Alignment FSM, slot counter, shadow capture and frame publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {SLOT_W{1'b0}};
      sh0_r   <= {W{1'b0}};
      sh1_r   <= {W{1'b0}};
      sh2_r   <= {W{1'b0}};
      d0_r    <= {W{1'b0}};
      d1_r    <= {W{1'b0}};
      d2_r    <= {W{1'b0}};
      d3_r    <= {W{1'b0}};
      fv_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      fv_r  <= 1'b0;
      err_r <= 1'b0;
      if (en) begin
        case (state_r)
          IDLE: begin
            if (sync) begin
              sh0_r   <= din;
              cnt_r   <= 2'd1;
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end
          RUN: begin
            if (sync) begin
              // A sync anywhere but slot 0 drops the partial frame and realigns here.
              err_r <= (cnt_r != 2'd0);
              sh0_r <= din;
              cnt_r <= 2'd1;
            end else begin
              case (cnt_r)
                2'd0: begin
                  err_r   <= 1'b1;
                  cnt_r   <= 2'd0;
                  state_r <= IDLE;
                end
                2'd1: begin
                  sh1_r <= din;
                  cnt_r <= 2'd2;
                end
                2'd2: begin
                  sh2_r <= din;
                  cnt_r <= 2'd3;
                end
                2'd3: begin
                  d0_r  <= sh0_r;
                  d1_r  <= sh1_r;
                  d2_r  <= sh2_r;
                  d3_r  <= din;
                  cnt_r <= 2'd0;
                  fv_r  <= 1'b1;
                end
                default: begin
                  cnt_r   <= 2'd0;
                  state_r <= IDLE;
                end
              endcase
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= {SLOT_W{1'b0}};
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign D0          = d0_r;
  assign D1          = d1_r;
  assign D2          = d2_r;
  assign D3          = d3_r;
  assign slot        = cnt_r;
  assign locked      = (state_r == RUN);
  assign frame_valid = fv_r;
  assign sync_err    = err_r;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench for tdm_demux_1x4: expected frames and error pulses are queued
// as stimulus is driven and retired when the DUT pulses frame_valid / sync_err.
module tb_tdm_demux_1x4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] D0, D1, D2, D3;
  logic [1:0]   slot;
  logic         locked, frame_valid, sync_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_fv_cyc = -1;
  int last_fv_cyc = -1;
  int err_exp = 0;
  int err_seen = 0;
  logic [4*W-1:0] fv_q[$];

  tdm_demux_1x4 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .slot(slot), .locked(locked),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Retire scoreboard entries whenever the DUT emits a pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid || sync_err)
        check("pulse_excl", {31'd0, frame_valid & sync_err}, 32'd0);
      if (frame_valid) begin
        prev_fv_cyc = last_fv_cyc;
        last_fv_cyc = cyc;
        if (fv_q.size() == 0) begin
          check("fv_unexpected", fv_q.size(), 32'd1);
        end else begin
          logic [4*W-1:0] f;
          f = fv_q.pop_front();
          check("D0", D0, f[4*W-1:3*W]);
          check("D1", D1, f[3*W-1:2*W]);
          check("D2", D2, f[2*W-1:W]);
          check("D3", D3, f[W-1:0]);
        end
      end
      if (sync_err) begin
        err_seen++;
        if (err_seen > err_exp) check("sync_err_unexpected", err_seen, err_exp);
      end
    end
  end

  task automatic sample(input logic s, input logic [W-1:0] d, input logic [1:0] exp_slot);
    @(negedge clk);
    en = 1'b1; sync = s; din = d;
    @(posedge clk);
    #1;
    check("slot", slot, exp_slot);
  endtask

  task automatic gap(input int n, input logic [1:0] exp_slot);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0; sync = 1'($urandom); din = W'($urandom);
      check("slot_hold", slot, exp_slot);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] a, b, c, d, input int g);
    sample(1'b1, a, 2'd1); gap(g, 2'd1);
    sample(1'b0, b, 2'd2); gap(g, 2'd2);
    sample(1'b0, c, 2'd3); gap(g, 2'd3);
    fv_q.push_back({a, b, c, d});
    sample(1'b0, d, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = '0;
    repeat (3) begin
      @(negedge clk);
      en = 1'($urandom); sync = 1'($urandom); din = W'($urandom);
    end
    check("rst_D", {D0, D1, D2, D3}, 32'd0);
    check("rst_slot", slot, 32'd0);
    check("rst_locked", locked, 32'd0);
    check("rst_pulses", {frame_valid, sync_err}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) sample(1'b0, W'($urandom), 2'd0);
    check("idle_locked", locked, 32'd0);

    // Basic frame
    send_frame(4'h5, 4'hA, 4'h3, 4'hC, 0);
    check("run_locked", locked, 32'd1);
    gap(2, 2'd0);

    // Gapped en, same frame
    send_frame(4'h5, 4'hA, 4'h3, 4'hC, 2);
    gap(2, 2'd0);

    // Back-to-back frames
    send_frame(4'h3, 4'h5, 4'h7, 4'h9, 0);
    send_frame(4'h1, 4'h2, 4'h4, 4'h8, 0);
    gap(2, 2'd0);
    check("fv_spacing", last_fv_cyc - prev_fv_cyc, 32'd4);
    check("b2b_final", {D0, D1, D2, D3}, 32'h1248);

    // Early sync at cnt=2
    sample(1'b1, 4'h6, 2'd1);
    sample(1'b0, 4'h7, 2'd2);
    err_exp++;
    sample(1'b1, 4'hE, 2'd1);
    gap(1, 2'd1);
    check("early_retain", {D0, D1, D2, D3}, 32'h1248);
    check("early_locked", locked, 32'd1);
    sample(1'b0, 4'h9, 2'd2);
    sample(1'b0, 4'hA, 2'd3);
    fv_q.push_back({4'hE, 4'h9, 4'hA, 4'hB});
    sample(1'b0, 4'hB, 2'd0);

    // Missing sync at cnt=0
    err_exp++;
    sample(1'b0, 4'hF, 2'd0);
    check("miss_locked", locked, 32'd0);
    check("miss_retain", {D0, D1, D2, D3}, 32'hE9AB);
    sample(1'b0, 4'h1, 2'd0);
    check("miss_idle", locked, 32'd0);

    // Async reset between edges at cnt=2
    sample(1'b1, 4'h2, 2'd1);
    sample(1'b0, 4'h3, 2'd2);
    #2;
    rst_n = 1'b0; en = 1'b0;
    #1;
    check("arst_D", {D0, D1, D2, D3}, 32'd0);
    check("arst_slot", slot, 32'd0);
    check("arst_locked", locked, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sample(1'b0, 4'h4, 2'd0);
    check("arst_needs_sync", locked, 32'd0);

    gap(3, 2'd0);
    check("fv_missing", fv_q.size(), 32'd0);
    check("sync_err_count", err_seen, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
